// File: rtl/e203_nice_csr_pkg.sv
// Shared types and encodings for the NICE extended-CSR read-modify-write sequencer.
package e203_nice_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_RW  = 2'b00;
  localparam logic [1:0] OP_RS  = 2'b01;
  localparam logic [1:0] OP_RC  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/e203_nice_csr_tmo.sv
// Handshake wait counter: counts cycles valid is held without ready and flags
// the cycle in which the wait limit would be reached. TIMEOUT=0 disables it.
module e203_nice_csr_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
      localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      // Wait counter: cleared on entry to a bus state, saturating at the limit.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
          cnt <= cnt + CW'(1);
        end else begin
          cnt <= cnt;
        end
      end

      // The edge that would bring the count to the limit is the expiry edge.
      assign expired = inc && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/e203_nice_csr_rmw.sv
// CSR instruction sequencer: turns one CSRRW/CSRRS/CSRRC request into at most
// one read and one write on the nice_csr bus and returns the old value.
// All outputs are registered; they are computed from the next state.
module e203_nice_csr_rmw
  import e203_nice_csr_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        nice_csr_valid,
  input  logic        nice_csr_ready,
  output logic [31:0] nice_csr_addr,
  output logic        nice_csr_wr,
  output logic [31:0] nice_csr_wdata,
  input  logic [31:0] nice_csr_rdata
);

  state_e      state, state_nx;

  logic [31:0] lat_addr, lat_addr_nx;
  logic [1:0]  lat_op, lat_op_nx;
  logic        lat_ren, lat_ren_nx;
  logic        lat_wen, lat_wen_nx;
  logic [31:0] lat_operand, lat_operand_nx;
  logic [31:0] old, old_nx;
  logic        err, err_nx;

  logic        req_ready_nx;
  logic        rsp_valid_nx;
  logic [31:0] rsp_rdata_nx;
  logic        rsp_err_nx;
  logic        bus_valid_nx;
  logic [31:0] bus_addr_nx;
  logic        bus_wr_nx;
  logic [31:0] bus_wdata_nx;
  logic [31:0] rmw_data;

  logic accept;
  logic hs;
  logic need_rd_in;
  logic tmo_clr;
  logic tmo_inc;
  logic expired;

  assign accept     = req_valid && req_ready;
  assign hs         = nice_csr_valid && nice_csr_ready;
  assign need_rd_in = req_ren || (req_wen && (req_op != OP_RW));
  assign tmo_inc    = nice_csr_valid && !nice_csr_ready;
  assign tmo_clr    = (state_nx != state);

  e203_nice_csr_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state selection; a handshake always wins over an expiring wait.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!accept) begin
          state_nx = ST_IDLE;
        end else if (req_op == OP_RSV) begin
          state_nx = ST_RSP;
        end else if (need_rd_in) begin
          state_nx = ST_RD;
        end else if (req_wen) begin
          state_nx = ST_WR;
        end else begin
          state_nx = ST_RSP;
        end
      end
      ST_RD: begin
        if (hs) begin
          state_nx = lat_wen ? ST_WR : ST_RSP;
        end else if (expired) begin
          state_nx = ST_RSP;
        end else begin
          state_nx = ST_RD;
        end
      end
      ST_WR: begin
        if (hs || expired) begin
          state_nx = ST_RSP;
        end else begin
          state_nx = ST_WR;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RSP;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next values of the latched request, captured old value and error flag.
  always_comb begin
    lat_addr_nx    = lat_addr;
    lat_op_nx      = lat_op;
    lat_ren_nx     = lat_ren;
    lat_wen_nx     = lat_wen;
    lat_operand_nx = lat_operand;
    old_nx         = old;
    err_nx         = err;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          lat_addr_nx    = req_addr;
          lat_op_nx      = req_op;
          lat_ren_nx     = req_ren;
          lat_wen_nx     = req_wen;
          lat_operand_nx = req_wdata;
          old_nx         = 32'h0000_0000;
          err_nx         = (req_op == OP_RSV);
        end else begin
          err_nx = err;
        end
      end
      ST_RD: begin
        if (hs) begin
          old_nx = nice_csr_rdata;
        end else if (expired) begin
          err_nx = 1'b1;
        end else begin
          old_nx = old;
        end
      end
      ST_WR: begin
        if (!hs && expired) begin
          err_nx = 1'b1;
        end else begin
          err_nx = err;
        end
      end
      ST_RSP:  err_nx = err;
      default: err_nx = err;
    endcase
  end

  // Output values for the next cycle, including the read-modify-write data.
  always_comb begin
    case (lat_op_nx)
      OP_RW:   rmw_data = lat_operand_nx;
      OP_RS:   rmw_data = old_nx | lat_operand_nx;
      OP_RC:   rmw_data = old_nx & ~lat_operand_nx;
      default: rmw_data = 32'h0000_0000;
    endcase

    req_ready_nx = (state_nx == ST_IDLE);
    rsp_valid_nx = (state_nx == ST_RSP);
    rsp_err_nx   = (state_nx == ST_RSP) && err_nx;
    bus_valid_nx = (state_nx == ST_RD) || (state_nx == ST_WR);
    bus_wr_nx    = (state_nx == ST_WR);

    if ((state_nx == ST_RSP) && lat_ren_nx && !err_nx) begin
      rsp_rdata_nx = old_nx;
    end else begin
      rsp_rdata_nx = 32'h0000_0000;
    end

    if (bus_valid_nx) begin
      bus_addr_nx = lat_addr_nx;
    end else begin
      bus_addr_nx = 32'h0000_0000;
    end

    if (bus_wr_nx) begin
      bus_wdata_nx = rmw_data;
    end else begin
      bus_wdata_nx = 32'h0000_0000;
    end
  end

  // Request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr       <= 32'h0000_0000;
      lat_op         <= OP_RW;
      lat_ren        <= 1'b0;
      lat_wen        <= 1'b0;
      lat_operand    <= 32'h0000_0000;
      old            <= 32'h0000_0000;
      err            <= 1'b0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 32'h0000_0000;
      rsp_err        <= 1'b0;
      nice_csr_valid <= 1'b0;
      nice_csr_addr  <= 32'h0000_0000;
      nice_csr_wr    <= 1'b0;
      nice_csr_wdata <= 32'h0000_0000;
    end else begin
      lat_addr       <= lat_addr_nx;
      lat_op         <= lat_op_nx;
      lat_ren        <= lat_ren_nx;
      lat_wen        <= lat_wen_nx;
      lat_operand    <= lat_operand_nx;
      old            <= old_nx;
      err            <= err_nx;
      req_ready      <= req_ready_nx;
      rsp_valid      <= rsp_valid_nx;
      rsp_rdata      <= rsp_rdata_nx;
      rsp_err        <= rsp_err_nx;
      nice_csr_valid <= bus_valid_nx;
      nice_csr_addr  <= bus_addr_nx;
      nice_csr_wr    <= bus_wr_nx;
      nice_csr_wdata <= bus_wdata_nx;
    end
  end

endmodule

// File: tb/tb_e203_nice_csr_rmw.sv
// Directed bench for e203_nice_csr_rmw with hand-computed expected values.
module tb_e203_nice_csr_rmw;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_op;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        nice_csr_valid;
  logic        nice_csr_ready;
  logic [31:0] nice_csr_addr;
  logic        nice_csr_wr;
  logic [31:0] nice_csr_wdata;
  logic [31:0] nice_csr_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int rd_base;
  int wr_base;
  logic [31:0] last_wdata = 32'h0;

  e203_nice_csr_rmw #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_op         (req_op),
    .req_ren        (req_ren),
    .req_wen        (req_wen),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .nice_csr_valid (nice_csr_valid),
    .nice_csr_ready (nice_csr_ready),
    .nice_csr_addr  (nice_csr_addr),
    .nice_csr_wr    (nice_csr_wr),
    .nice_csr_wdata (nice_csr_wdata),
    .nice_csr_rdata (nice_csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: counts completed read and write transfers.
  always @(posedge clk) begin
    if (!rst && nice_csr_valid && nice_csr_ready) begin
      if (nice_csr_wr) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= nice_csr_wdata;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ren, input logic wen);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_ren   = ren;
    req_wen   = wen;
    req_valid = 1'b1;
    rd_base   = rd_cnt;
    wr_base   = wr_cnt;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_addr       = 32'h0;
    req_op         = 2'b00;
    req_ren        = 1'b0;
    req_wen        = 1'b0;
    req_wdata      = 32'h0;
    rsp_ready      = 1'b1;
    nice_csr_ready = 1'b1;
    nice_csr_rdata = 32'h0;
    step(); step();

    // Reset state
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_bus_valid", {31'h0, nice_csr_valid}, 32'h0);
    check("rst_bus_addr", nice_csr_addr, 32'h0);
    check("rst_bus_wr", {31'h0, nice_csr_wr}, 32'h0);
    check("rst_bus_wdata", nice_csr_wdata, 32'h0);
    rst = 1'b0;
    step();

    // CSRRS read-modify-write
    nice_csr_rdata = 32'h1234_5600;
    check("rs_c0_ready", {31'h0, req_ready}, 32'h1);
    issue(2'b01, 32'h0000_0BC0, 32'h0000_00F0, 1'b1, 1'b1);
    check("rs_c1_valid", {31'h0, nice_csr_valid}, 32'h1);
    check("rs_c1_wr", {31'h0, nice_csr_wr}, 32'h0);
    check("rs_c1_addr", nice_csr_addr, 32'h0000_0BC0);
    check("rs_c1_ready", {31'h0, req_ready}, 32'h0);
    step();
    check("rs_c2_valid", {31'h0, nice_csr_valid}, 32'h1);
    check("rs_c2_wr", {31'h0, nice_csr_wr}, 32'h1);
    check("rs_c2_wdata", nice_csr_wdata, 32'h1234_56F0);
    check("rs_c2_addr", nice_csr_addr, 32'h0000_0BC0);
    step();
    check("rs_c3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rs_c3_rdata", rsp_rdata, 32'h1234_5600);
    check("rs_c3_err", {31'h0, rsp_err}, 32'h0);
    check("rs_c3_bus_valid", {31'h0, nice_csr_valid}, 32'h0);
    check("rs_c3_req_ready", {31'h0, req_ready}, 32'h0);
    step();
    check("rs_c4_req_ready", {31'h0, req_ready}, 32'h1);
    check("rs_c4_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rs_rd_count", rd_cnt - rd_base, 32'd1);
    check("rs_wr_count", wr_cnt - wr_base, 32'd1);

    // CSRRC with ren=0
    nice_csr_rdata = 32'hFFFF_FFFF;
    issue(2'b10, 32'h0000_0BC1, 32'h0000_00FF, 1'b0, 1'b1);
    check("rc_c1_wr", {31'h0, nice_csr_wr}, 32'h0);
    step();
    check("rc_c2_wdata", nice_csr_wdata, 32'hFFFF_FF00);
    step();
    check("rc_c3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rc_c3_rdata", rsp_rdata, 32'h0);
    step();
    check("rc_last_wdata", last_wdata, 32'hFFFF_FF00);

    // CSRRW write-only
    nice_csr_rdata = 32'h5555_5555;
    issue(2'b00, 32'h0000_0BC2, 32'hA5A5_0001, 1'b0, 1'b1);
    check("rw_c1_wr", {31'h0, nice_csr_wr}, 32'h1);
    check("rw_c1_wdata", nice_csr_wdata, 32'hA5A5_0001);
    step();
    check("rw_c2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rw_c2_rdata", rsp_rdata, 32'h0);
    step();
    check("rw_rd_count", rd_cnt - rd_base, 32'd0);
    check("rw_wr_count", wr_cnt - wr_base, 32'd1);

    // CSRRS read-only
    nice_csr_rdata = 32'hCAFE_0001;
    issue(2'b01, 32'h0000_0BC3, 32'h0000_0000, 1'b1, 1'b0);
    check("ro_c1_valid", {31'h0, nice_csr_valid}, 32'h1);
    check("ro_c1_wr", {31'h0, nice_csr_wr}, 32'h0);
    step();
    check("ro_c2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("ro_c2_rdata", rsp_rdata, 32'hCAFE_0001);
    check("ro_c2_bus_valid", {31'h0, nice_csr_valid}, 32'h0);
    step();
    check("ro_wr_count", wr_cnt - wr_base, 32'd0);

    // Timeout with ready held low
    nice_csr_ready = 1'b0;
    nice_csr_rdata = 32'hDEAD_BEEF;
    issue(2'b01, 32'h0000_0BC4, 32'h0000_000F, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("tmo_c%0d_valid", i), {31'h0, nice_csr_valid}, 32'h1);
      check($sformatf("tmo_c%0d_rsp", i), {31'h0, rsp_valid}, 32'h0);
      step();
    end
    check("tmo_c5_valid", {31'h0, nice_csr_valid}, 32'h0);
    check("tmo_c5_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("tmo_c5_err", {31'h0, rsp_err}, 32'h1);
    check("tmo_c5_rdata", rsp_rdata, 32'h0);
    step();
    check("tmo_wr_count", wr_cnt - wr_base, 32'd0);
    check("tmo_req_ready", {31'h0, req_ready}, 32'h1);
    nice_csr_ready = 1'b1;

    // Reserved op
    issue(2'b11, 32'h0000_0BC5, 32'h0000_0001, 1'b1, 1'b1);
    check("rsv_c1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rsv_c1_err", {31'h0, rsp_err}, 32'h1);
    check("rsv_c1_rdata", rsp_rdata, 32'h0);
    check("rsv_c1_bus_valid", {31'h0, nice_csr_valid}, 32'h0);
    step();
    check("rsv_bus_count", (rd_cnt - rd_base) + (wr_cnt - wr_base), 32'd0);

    // Response held by rsp_ready=0
    rsp_ready      = 1'b0;
    nice_csr_rdata = 32'h0BAD_F00D;
    issue(2'b10, 32'h0000_0BC6, 32'h0000_0000, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_%0d_rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("hold_%0d_rdata", i), rsp_rdata, 32'h0BAD_F00D);
      check($sformatf("hold_%0d_req_ready", i), {31'h0, req_ready}, 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("hold_done_req_ready", {31'h0, req_ready}, 32'h1);
    check("hold_done_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset during a stalled write
    nice_csr_ready = 1'b0;
    issue(2'b00, 32'h0000_0BC7, 32'h1111_2222, 1'b0, 1'b1);
    check("rstwr_c1_wr", {31'h0, nice_csr_wr}, 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    nice_csr_ready = 1'b1;
    check("rstwr_valid", {31'h0, nice_csr_valid}, 32'h0);
    check("rstwr_req_ready", {31'h0, req_ready}, 32'h1);
    check("rstwr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rstwr_wdata", nice_csr_wdata, 32'h0);
    check("rstwr_wr_count", wr_cnt - wr_base, 32'd0);

    // No-op after reset: one-cycle response
    issue(2'b01, 32'h0000_0BC8, 32'h0000_0000, 1'b0, 1'b0);
    check("nop_c1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("nop_c1_err", {31'h0, rsp_err}, 32'h0);
    check("nop_c1_bus_valid", {31'h0, nice_csr_valid}, 32'h0);
    step();
    check("nop_c2_req_ready", {31'h0, req_ready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
